// File: rtl/dadda_accum_if.sv
// Product-in / group-sum-out bus between the 4x4 multiplier and its accumulate stage.
// Both directions use valid/ready: a beat transfers on any rising edge where valid && ready.
interface dadda_accum_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 10,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, flush, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/dadda_accum_stage.sv
// Accumulates groups of multiplier products and emits one registered sum per group,
// with product count and a sticky carry-out flag.
module dadda_accum_stage #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 10,
    parameter int LEN    = 4,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    dadda_accum_if.slave       bus,
    output logic               state_dbg
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              res_ovf_q, res_ovf_d;

    logic              accept;
    logic [ACC_W:0]    prod_ext;
    logic [ACC_W:0]    acc_sum;
    logic [ACC_W-1:0]  acc_new;
    logic [CNT_W-1:0]  cnt_new;
    logic              ovf_new;
    logic              closes;

    // in_ready depends only on state and out_ready; HOLD passes the consumer's ready through
    // so a new group's first product can enter in the same cycle the result leaves.
    assign bus.in_ready = (state_q == ACCUM) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // acc/cnt/ovf are cleared on every close, so in HOLD they already hold the empty-group base.
    assign prod_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_prod};
    assign acc_sum  = {1'b0, acc_q} + prod_ext;
    assign acc_new  = acc_sum[ACC_W-1:0];
    assign ovf_new  = ovf_q | acc_sum[ACC_W];
    assign cnt_new  = cnt_q + 1'b1;

    // Flush only closes a group from ACCUM; in HOLD it is ignored even alongside an accept.
    assign closes = (cnt_new == LEN_C) || bus.in_last || ((state_q == ACCUM) && bus.flush);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        count_d   = count_q;
        res_ovf_d = res_ovf_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (closes) begin
                        sum_d     = acc_new;
                        count_d   = cnt_new;
                        res_ovf_d = ovf_new;
                        acc_d     = '0;
                        cnt_d     = '0;
                        ovf_d     = 1'b0;
                        state_d   = HOLD;
                    end else begin
                        acc_d = acc_new;
                        cnt_d = cnt_new;
                        ovf_d = ovf_new;
                    end
                end else if (bus.flush && (cnt_q != '0)) begin
                    sum_d     = acc_q;
                    count_d   = cnt_q;
                    res_ovf_d = ovf_q;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                    if (accept) begin
                        if (closes) begin
                            sum_d     = acc_new;
                            count_d   = cnt_new;
                            res_ovf_d = ovf_new;
                            state_d   = HOLD;
                        end else begin
                            acc_d = acc_new;
                            cnt_d = cnt_new;
                            ovf_d = ovf_new;
                        end
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            count_q   <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_sum   = sum_q;
    assign bus.out_count = count_q;
    assign bus.out_ovf   = res_ovf_q;
    assign state_dbg     = state_q;

endmodule
